hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch squash, memory freeze with timeout, halt.
// Latency: stage enables/flushes are combinational from state and inputs; state moves on the next edge.
// Backpressure: freeze (mem_req & ~mem_ready) holds every stage. HAZARD_STATS_EN adds stall/flush counters.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dx_memread,
    input  logic [3:0] dx_rt,
    input  logic [3:0] fd_rs,
    input  logic [3:0] fd_rt,
    input  logic       fd_uses_rt,
    input  logic       branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       wb_halt,
    output logic       pc_write,
    output logic       fd_write,
    output logic       dx_write,
    output logic       xm_write,
    output logic       fd_flush,
    output logic       dx_flush,
    output logic       halted,
    output logic       mem_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic freeze;
    logic load_use;
    logic pc_write_raw, fd_write_raw, dx_write_raw, xm_write_raw;
    logic fd_flush_raw, dx_flush_raw;

    assign freeze   = mem_req & ~mem_ready;
    assign load_use = dx_memread & (dx_rt != 4'd0) &
                      ((dx_rt == fd_rs) | (fd_uses_rt & (dx_rt == fd_rt)));

    // Enables before reset gating; the stats counters use these so rst_n stays a pure async reset.
    always_comb begin
        pc_write_raw = 1'b0;
        fd_write_raw = 1'b0;
        dx_write_raw = 1'b0;
        xm_write_raw = 1'b0;
        fd_flush_raw = 1'b0;
        dx_flush_raw = 1'b0;
        if (state_q != ST_HALTED) begin
            if (freeze) begin
                pc_write_raw = 1'b0;
            end else if (branch_taken) begin
                pc_write_raw = 1'b1;
                fd_write_raw = 1'b1;
                dx_write_raw = 1'b1;
                xm_write_raw = 1'b1;
                fd_flush_raw = 1'b1;
                dx_flush_raw = 1'b1;
            end else if (load_use) begin
                dx_write_raw = 1'b1;
                xm_write_raw = 1'b1;
                dx_flush_raw = 1'b1;
            end else begin
                pc_write_raw = 1'b1;
                fd_write_raw = 1'b1;
                dx_write_raw = 1'b1;
                xm_write_raw = 1'b1;
            end
        end
    end

    assign pc_write    = rst_n & pc_write_raw;
    assign fd_write    = rst_n & fd_write_raw;
    assign dx_write    = rst_n & dx_write_raw;
    assign xm_write    = rst_n & xm_write_raw;
    assign fd_flush    = rst_n & fd_flush_raw;
    assign dx_flush    = rst_n & dx_flush_raw;
    assign halted      = rst_n & (state_q == ST_HALTED);
    assign mem_timeout = mem_timeout_q;

    // A halt seen while frozen is not acted on: the HLT is still held in MEM/WB once the freeze lifts.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end else if (wb_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_MEM_WAIT: begin
                if (freeze) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_q == 8'd254) begin
                        state_d       = ST_HALTED;
                        mem_timeout_d = 1'b1;
                    end
                end else if (wb_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != ST_HALTED) && !pc_write_raw && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (fd_flush_raw && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
